// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter:
// FSM encoding, master identifiers and the latched request bundle.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_LDR = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned TO_CNT_W        = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  // A write with no byte lanes enabled has nothing to do on the slave bus.
  function automatic logic is_null_write(input mem_req_t r);
    return r.we && (r.be == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: the master not granted last
// wins a tie; a lone requester always wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t last_grant_i,
  output logic [1:0] grant_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == MASTER_CPU) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master to one-slave memory port arbiter with round-robin grant,
// registered slave request, bounded slave wait and one-cycle completion pulses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  input  logic        s_ack,
  input  logic [31:0] s_rdata
);

  // Counter value on the last BUSY cycle the slave is allowed before abort.
  localparam logic [TO_CNT_W-1:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e                state_q;
  master_id_t            owner_q;
  master_id_t            last_grant_q;
  mem_req_t              slv_q;
  logic                  s_req_q;
  logic [TO_CNT_W-1:0]   to_cnt_q;
  logic [1:0]            ack_q;
  logic [1:0]            err_q;
  logic [31:0]           rdata_q;

  logic [1:0]            req_vec;
  logic [1:0]            grant;
  master_id_t            grant_id_d;
  mem_req_t [1:0]        m_fields;
  mem_req_t              sel_req_d;

  assign req_vec     = {m1_req, m0_req};
  assign m_fields[0] = {m0_we, m0_addr, m0_wdata, m0_be};
  assign m_fields[1] = {m1_we, m1_addr, m1_wdata, m1_be};

  rr_arb2 u_rr_arb2 (
    .req_i        (req_vec),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign grant_id_d = grant[1] ? MASTER_LDR : MASTER_CPU;
  assign sel_req_d  = m_fields[grant_id_d];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= MASTER_CPU;
      last_grant_q <= MASTER_LDR;
      slv_q        <= '0;
      s_req_q      <= 1'b0;
      to_cnt_q     <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      // Completion flags are pulses; they are only raised on entry to RESP.
      ack_q <= '0;
      err_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            owner_q      <= grant_id_d;
            last_grant_q <= grant_id_d;
            slv_q        <= sel_req_d;
            to_cnt_q     <= '0;
            if (is_null_write(sel_req_d)) begin
              state_q           <= ST_RESP;
              ack_q[grant_id_d] <= 1'b1;
              rdata_q           <= '0;
            end else begin
              state_q <= ST_BUSY;
              s_req_q <= 1'b1;
            end
          end
        end

        ST_BUSY: begin
          if (s_ack) begin
            s_req_q        <= 1'b0;
            state_q        <= ST_RESP;
            ack_q[owner_q] <= 1'b1;
            rdata_q        <= s_rdata;
          end else if (to_cnt_q == TO_LAST) begin
            s_req_q        <= 1'b0;
            state_q        <= ST_RESP;
            ack_q[owner_q] <= 1'b1;
            err_q[owner_q] <= 1'b1;
            rdata_q        <= '0;
            to_cnt_q       <= to_cnt_q + 8'd1;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end

        ST_RESP: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack   = ack_q[0];
  assign m0_err   = err_q[0];
  assign m0_rdata = rdata_q;
  assign m1_ack   = ack_q[1];
  assign m1_err   = err_q[1];
  assign m1_rdata = rdata_q;

  assign s_req   = s_req_q;
  assign s_we    = slv_q.we;
  assign s_addr  = slv_q.addr;
  assign s_wdata = slv_q.wdata;
  assign s_be    = slv_q.be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a transaction-level schedule model predicts every
// cycle's outputs; directed scenarios add hand-computed latency/data checks.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk, reset_n;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        s_req, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_be(s_be), .s_ack(s_ack), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          mst;
    bit          err;
    logic [31:0] rdata;
  } ack_rec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          sreq_count = 0;
  ack_rec_t    ack_log[$];
  mem_req_t    mq0[$];
  mem_req_t    mq1[$];

  // Model schedule of the transaction in flight (absolute cycle numbers).
  bit          sched_valid;
  int          sreq_lo, sreq_hi, ack_cyc, free_cyc;
  bit          owner, last_grant, exp_err;
  logic [31:0] exp_rdata;
  mem_req_t    exp_fields;

  // Slave responder configuration: ack after slave_delay waits, -1 = never.
  int          slave_delay;
  logic [31:0] slave_rdata;
  bit          stray_ack;
  int          wait_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sched_valid = 1'b0;
    free_cyc    = 0;
    last_grant  = 1'b1;
    wait_cnt    = 0;
  endtask

  task automatic compare_outputs();
    bit exp_sreq, ea0, ea1;
    if (!reset_n) begin
      check("rst_s_req", s_req, 0);
      check("rst_s_we", s_we, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_s_wdata", s_wdata, 0);
      check("rst_s_be", s_be, 0);
      check("rst_m0_ack", m0_ack, 0);
      check("rst_m1_ack", m1_ack, 0);
      check("rst_m0_err", m0_err, 0);
      check("rst_m1_err", m1_err, 0);
      check("rst_rdata", m0_rdata, 0);
      return;
    end
    exp_sreq = sched_valid && cyc >= sreq_lo && cyc <= sreq_hi;
    check("s_req", s_req, exp_sreq);
    if (exp_sreq) begin
      check("s_we", s_we, exp_fields.we);
      check("s_addr", s_addr, exp_fields.addr);
      check("s_wdata", s_wdata, exp_fields.wdata);
      check("s_be", s_be, exp_fields.be);
    end
    ea0 = sched_valid && cyc == ack_cyc && owner == 1'b0;
    ea1 = sched_valid && cyc == ack_cyc && owner == 1'b1;
    check("m0_ack", m0_ack, ea0);
    check("m1_ack", m1_ack, ea1);
    if (ea0) begin
      check("m0_err", m0_err, exp_err);
      check("m0_rdata", m0_rdata, exp_rdata);
    end
    if (ea1) begin
      check("m1_err", m1_err, exp_err);
      check("m1_rdata", m1_rdata, exp_rdata);
    end
  endtask

  // Masters hold the head of their queue until acked; idle masters wiggle
  // their fields to show ungranted inputs have no effect.
  task automatic drive_masters();
    if (m0_ack && mq0.size() > 0) mq0.delete(0);
    if (m1_ack && mq1.size() > 0) mq1.delete(0);
    if (mq0.size() > 0) begin
      m0_req = 1'b1; m0_we = mq0[0].we; m0_addr = mq0[0].addr;
      m0_wdata = mq0[0].wdata; m0_be = mq0[0].be;
    end else begin
      m0_req = 1'b0; m0_we = 1'($urandom); m0_addr = $urandom;
      m0_wdata = $urandom; m0_be = 4'($urandom);
    end
    if (mq1.size() > 0) begin
      m1_req = 1'b1; m1_we = mq1[0].we; m1_addr = mq1[0].addr;
      m1_wdata = mq1[0].wdata; m1_be = mq1[0].be;
    end else begin
      m1_req = 1'b0; m1_we = 1'($urandom); m1_addr = $urandom;
      m1_wdata = $urandom; m1_be = 4'($urandom);
    end
  endtask

  task automatic drive_slave();
    if (s_req) begin
      if (slave_delay >= 0 && wait_cnt == slave_delay) begin
        s_ack = 1'b1; s_rdata = slave_rdata;
      end else begin
        s_ack = 1'b0; s_rdata = $urandom;
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      s_ack    = stray_ack;
      s_rdata  = $urandom;
    end
  endtask

  // Decide from the request about to be sampled what the whole transaction
  // must look like: slave window, completion cycle, data and error.
  task automatic model_try_start();
    bit       w;
    mem_req_t t;
    if (!reset_n || cyc < free_cyc || !(m0_req || m1_req)) return;
    if (m0_req && m1_req) w = ~last_grant;
    else                  w = m1_req;
    t = w ? mem_req_t'{m1_we, m1_addr, m1_wdata, m1_be}
          : mem_req_t'{m0_we, m0_addr, m0_wdata, m0_be};
    last_grant  = w;
    owner       = w;
    exp_fields  = t;
    sched_valid = 1'b1;
    sreq_lo     = cyc + 1;
    if (t.we && t.be == 4'b0000) begin
      sreq_hi = cyc; ack_cyc = cyc + 1; exp_rdata = '0; exp_err = 1'b0;
    end else if (slave_delay >= 0 && slave_delay < TO) begin
      sreq_hi = cyc + 1 + slave_delay; ack_cyc = sreq_hi + 1;
      exp_rdata = slave_rdata; exp_err = 1'b0;
    end else begin
      sreq_hi = cyc + TO; ack_cyc = cyc + TO + 1; exp_rdata = '0; exp_err = 1'b1;
    end
    free_cyc = ack_cyc + 1;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    compare_outputs();
    if (s_req) sreq_count++;
    if (m0_ack) ack_log.push_back('{cyc: cyc, mst: 1'b0, err: m0_err, rdata: m0_rdata});
    if (m1_ack) ack_log.push_back('{cyc: cyc, mst: 1'b1, err: m1_err, rdata: m1_rdata});
    drive_masters();
    drive_slave();
    model_try_start();
  endtask

  task automatic run_until_done(input int max_cycles);
    int n = 0;
    bit done;
    done = 1'b0;
    while (n < max_cycles) begin
      done = (mq0.size() == 0) && (mq1.size() == 0) && (cyc >= free_cyc);
      if (done) break;
      step();
      n++;
    end
    done = (mq0.size() == 0) && (mq1.size() == 0) && (cyc >= free_cyc);
    check("drain_within_bound", done, 1);
  endtask

  task automatic push_txn(input bit m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    mem_req_t r;
    r = '{we: we, addr: addr, wdata: wdata, be: be};
    if (m) mq1.push_back(r);
    else   mq0.push_back(r);
  endtask

  task automatic begin_test(input int start);
    t0 = start;
    sreq_count = 0;
    ack_log.delete();
  endtask

  task automatic check_txn(input string name, input int idx, input int lat,
                           input bit mst, input bit err, input logic [31:0] rdata);
    if (idx < ack_log.size()) begin
      check({name, "_lat"}, ack_log[idx].cyc - t0, lat);
      check({name, "_mst"}, ack_log[idx].mst, mst);
      check({name, "_err"}, ack_log[idx].err, err);
      check({name, "_rdata"}, ack_log[idx].rdata, rdata);
    end else begin
      check({name, "_present"}, ack_log.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    s_ack = 1'b0; s_rdata = '0;
    slave_delay = 0; slave_rdata = '0; stray_ack = 1'b0;
    model_reset();
    drive_masters();
    repeat (3) step();

    // Write right out of reset, zero-wait slave; first edge after release grants.
    push_txn(1'b0, 1'b1, 32'h10, 32'h0000_AB00, 4'b0010);
    slave_delay = 0; slave_rdata = 32'h1234_5678;
    begin_test(cyc);
    reset_n = 1'b1;
    drive_masters();
    model_try_start();
    run_until_done(40);
    check_txn("t1", 0, 2, 1'b0, 1'b0, 32'h1234_5678);
    check("t1_sreq_cycles", sreq_count, 1);

    // M1 read, slave acks after 3 waits (coincides with the last allowed cycle).
    push_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    slave_delay = 3; slave_rdata = 32'hDEAD_BEEF;
    begin_test(cyc + 1);
    run_until_done(40);
    check_txn("t2", 0, 5, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("t2_sreq_cycles", sreq_count, 4);

    // Both masters contend repeatedly; grants alternate starting with M0.
    push_txn(1'b0, 1'b1, 32'h100, 32'h1111_0000, 4'hF);
    push_txn(1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
    push_txn(1'b1, 1'b1, 32'h200, 32'h2222_0000, 4'h3);
    push_txn(1'b1, 1'b0, 32'h204, 32'h0, 4'hC);
    slave_delay = 1; slave_rdata = 32'hA5A5_0001;
    begin_test(cyc + 1);
    run_until_done(80);
    check_txn("t3a", 0, 3, 1'b0, 1'b0, 32'hA5A5_0001);
    check_txn("t3b", 1, 7, 1'b1, 1'b0, 32'hA5A5_0001);
    check_txn("t3c", 2, 11, 1'b0, 1'b0, 32'hA5A5_0001);
    check_txn("t3d", 3, 15, 1'b1, 1'b0, 32'hA5A5_0001);

    // Slave never answers: abort after TIMEOUT cycles; stray acks outside BUSY.
    push_txn(1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    slave_delay = -1; slave_rdata = 32'hFFFF_FFFF; stray_ack = 1'b1;
    begin_test(cyc + 1);
    run_until_done(40);
    check_txn("t4", 0, 5, 1'b0, 1'b1, 32'h0);
    check("t4_sreq_cycles", sreq_count, 4);

    // Write with no byte enables completes without touching the slave.
    push_txn(1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 4'b0000);
    slave_delay = 0; slave_rdata = 32'h5555_AAAA;
    begin_test(cyc + 1);
    run_until_done(40);
    check_txn("t5", 0, 1, 1'b0, 1'b0, 32'h0);
    check("t5_sreq_cycles", sreq_count, 0);

    // Back-to-back reads from M1: one completion every three cycles.
    push_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    push_txn(1'b1, 1'b0, 32'h304, 32'h0, 4'hF);
    push_txn(1'b1, 1'b0, 32'h308, 32'h0, 4'hF);
    stray_ack = 1'b0; slave_delay = 0; slave_rdata = 32'h0BAD_F00D;
    begin_test(cyc + 1);
    run_until_done(60);
    check_txn("t6a", 0, 2, 1'b1, 1'b0, 32'h0BAD_F00D);
    check_txn("t6b", 1, 5, 1'b1, 1'b0, 32'h0BAD_F00D);
    check_txn("t6c", 2, 8, 1'b1, 1'b0, 32'h0BAD_F00D);
    check("t6_sreq_cycles", sreq_count, 3);

    // Read with no byte enables still goes to the slave.
    push_txn(1'b0, 1'b0, 32'h50, 32'h0, 4'b0000);
    slave_delay = 2; slave_rdata = 32'h0000_0042;
    begin_test(cyc + 1);
    run_until_done(40);
    check_txn("t7", 0, 4, 1'b0, 1'b0, 32'h0000_0042);
    check("t7_sreq_cycles", sreq_count, 3);

    // Reset in the second BUSY cycle: s_req drops at once, nothing completes.
    push_txn(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    slave_delay = -1;
    begin_test(cyc + 1);
    repeat (3) step();
    check("t8_busy_s_req", s_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t8_async_s_req", s_req, 0);
    check("t8_async_m1_ack", m1_ack, 0);
    mq1.delete();
    model_reset();
    drive_masters();
    repeat (2) step();
    reset_n = 1'b1;
    begin_test(cyc);
    repeat (8) step();
    check("t8_no_ack_after_release", ack_log.size(), 0);
    check("t8_no_sreq_after_release", sreq_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
